// File: rtl/multiword_add_seq_pkg.sv
// Shared types and constants for the sequential multi-word adder.
// Optional signed-overflow output is enabled with the MWA_OVERFLOW_EN macro.
package mwa_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam int unsigned DefaultW      = 8;
    localparam int unsigned DefaultNWords = 4;

    // Chunk index width; a single-chunk build still keeps a 1-bit counter.
    function automatic int unsigned idx_width(input int unsigned n_words);
        return (n_words <= 1) ? 1 : $clog2(n_words);
    endfunction

endpackage

// File: rtl/multiword_add_seq_if.sv
// Operand/result handshake bundle for multiword_add_seq.
// The ovf signal exists only when MWA_OVERFLOW_EN is defined.
interface multiword_add_seq_if
    import mwa_pkg::*;
#(
    parameter int unsigned W       = DefaultW,
    parameter int unsigned N_WORDS = DefaultNWords
);
    logic                   in_valid;
    logic                   in_ready;
    logic [W*N_WORDS-1:0]   a;
    logic [W*N_WORDS-1:0]   b;
    logic                   cin;
    logic                   out_valid;
    logic                   out_ready;
    logic [W*N_WORDS-1:0]   sum;
    logic                   cout;
    logic                   busy;
`ifdef MWA_OVERFLOW_EN
    logic                   ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
`endif

endinterface

// File: rtl/multiword_add_seq_cla_chunk_add.sv
// W-bit combinational carry-look-ahead chunk adder built from per-bit generate/propagate.
module cla_chunk_add #(
    parameter int unsigned W = 8
) (
    output logic [W-1:0] sum,
    output logic         cout,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin
);
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   carry;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        carry    = '0;
        carry[0] = cin;
        for (int i = 0; i < W; i++) begin
            carry[i+1] = g[i] | (p[i] & carry[i]);
        end
    end

    assign sum  = p ^ carry[W-1:0];
    assign cout = carry[W];

endmodule

// File: rtl/multiword_add_seq.sv
// Sequential W*N_WORDS-bit adder feeding one W-bit chunk per cycle through a CLA, LSB chunk first.
// Define MWA_OVERFLOW_EN to add the registered signed-overflow output ovf.
module multiword_add_seq
    import mwa_pkg::*;
#(
    parameter int unsigned W       = DefaultW,
    parameter int unsigned N_WORDS = DefaultNWords
) (
    input logic               clk,
    input logic               rst,
    multiword_add_seq_if.slave bus
);
    localparam int unsigned Total = W * N_WORDS;
    localparam int unsigned IdxW  = idx_width(N_WORDS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N_WORDS - 1);

    state_e            state_q;
    logic [Total-1:0]  a_q;
    logic [Total-1:0]  b_q;
    logic [Total-1:0]  sum_q;
    logic [IdxW-1:0]   idx_q;
    logic              carry_q;
    logic              cout_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              busy_q;

    logic [W-1:0]      chunk_a;
    logic [W-1:0]      chunk_b;
    logic [W-1:0]      chunk_sum;
    logic              chunk_cout;

    always_comb begin
        chunk_a = '0;
        chunk_b = '0;
        for (int i = 0; i < N_WORDS; i++) begin
            if (idx_q == IdxW'(i)) begin
                chunk_a = a_q[i*W +: W];
                chunk_b = b_q[i*W +: W];
            end
        end
    end

    cla_chunk_add #(
        .W (W)
    ) u_cla (
        .sum  (chunk_sum),
        .cout (chunk_cout),
        .a    (chunk_a),
        .b    (chunk_b),
        .cin  (carry_q)
    );

`ifdef MWA_OVERFLOW_EN
    logic ovf_q;

    // On the last RUN edge chunk_sum is the top chunk, so its MSB is the result MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (state_q == StRun && idx_q == LastIdx) begin
            ovf_q <= (a_q[Total-1] == b_q[Total-1]) && (chunk_sum[W-1] != a_q[Total-1]);
        end
    end

    assign bus.ovf = ovf_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        carry_q    <= bus.cin;
                        idx_q      <= '0;
                        state_q    <= StRun;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                StRun: begin
                    for (int i = 0; i < N_WORDS; i++) begin
                        if (idx_q == IdxW'(i)) begin
                            sum_q[i*W +: W] <= chunk_sum;
                        end
                    end
                    carry_q <= chunk_cout;
                    if (idx_q == LastIdx) begin
                        cout_q      <= chunk_cout;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed self-checking bench for multiword_add_seq (4-chunk and 1-chunk instances).
// ovf checks are compiled in when MWA_OVERFLOW_EN is defined.
module tb_multiword_add_seq;
    import mwa_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    multiword_add_seq_if #(.W(8), .N_WORDS(4)) bus4 ();
    multiword_add_seq_if #(.W(8), .N_WORDS(1)) bus1 ();

    multiword_add_seq #(
        .W       (8),
        .N_WORDS (4)
    ) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    multiword_add_seq #(
        .W       (8),
        .N_WORDS (1)
    ) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Handshake one operand set into the 4-chunk DUT and wait (bounded) for out_valid.
    task automatic run4(input logic [31:0] a, input logic [31:0] b, input logic c,
                        output int lat);
        @(posedge clk); #1;
        bus4.a = a;
        bus4.b = b;
        bus4.cin = c;
        bus4.in_valid = 1'b1;
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        lat = 0;
        while (bus4.out_valid !== 1'b1 && lat < 20) begin
            chk("excl_ready_valid", 64'(bus4.in_ready & bus4.out_valid), 64'd0);
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release4();
        bus4.out_ready = 1'b1;
        @(posedge clk); #1;
        bus4.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  lat;
        logic seen;

        bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0; bus4.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.out_ready = 1'b0;

        #12;
        chk("rst_in_ready", 64'(bus4.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus4.out_valid), 64'd0);
        chk("rst_sum", 64'(bus4.sum), 64'd0);
        chk("rst_cout", 64'(bus4.cout), 64'd0);
        chk("rst_busy", 64'(bus4.busy), 64'd0);
        chk("rst_in_ready_n1", 64'(bus1.in_ready), 64'd1);
`ifdef MWA_OVERFLOW_EN
        chk("rst_ovf", 64'(bus4.ovf), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Carry ripples through every chunk boundary.
        run4(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat);
        chk("ripple_latency", 64'(lat), 64'd4);
        chk("ripple_sum", 64'(bus4.sum), 64'h0);
        chk("ripple_cout", 64'(bus4.cout), 64'd1);
        chk("ripple_in_ready", 64'(bus4.in_ready), 64'd0);
        chk("ripple_busy", 64'(bus4.busy), 64'd1);
        release4();
        chk("ripple_back_idle", 64'(bus4.in_ready), 64'd1);

        run4(32'h1234_5678, 32'h0000_0000, 1'b1, lat);
        chk("cin_sum", 64'(bus4.sum), 64'h1234_5679);
        chk("cin_cout", 64'(bus4.cout), 64'd0);
        release4();

        run4(32'h00FF_00FF, 32'h0001_0001, 1'b0, lat);
        chk("mid_carry_sum", 64'(bus4.sum), 64'h0100_0100);
        chk("mid_carry_cout", 64'(bus4.cout), 64'd0);
        release4();

        // Backpressure: result held, new in_valid ignored.
        run4(32'h8000_0000, 32'h8000_0000, 1'b0, lat);
        chk("bp_sum", 64'(bus4.sum), 64'h0);
        chk("bp_cout", 64'(bus4.cout), 64'd1);
        bus4.a = 32'h0000_0001;
        bus4.b = 32'h0000_0001;
        bus4.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", 64'(bus4.out_valid), 64'd1);
            chk("bp_hold_sum", 64'(bus4.sum), 64'h0);
            chk("bp_hold_cout", 64'(bus4.cout), 64'd1);
            chk("bp_hold_in_ready", 64'(bus4.in_ready), 64'd0);
        end
        bus4.in_valid = 1'b0;
        release4();
        chk("bp_release_in_ready", 64'(bus4.in_ready), 64'd1);
        chk("bp_release_out_valid", 64'(bus4.out_valid), 64'd0);
        chk("bp_release_busy", 64'(bus4.busy), 64'd0);

        // Reset two edges into RUN.
        @(posedge clk); #1;
        bus4.a = 32'h1111_1111;
        bus4.b = 32'h2222_2222;
        bus4.cin = 1'b0;
        bus4.in_valid = 1'b1;
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_in_ready", 64'(bus4.in_ready), 64'd1);
        chk("abort_out_valid", 64'(bus4.out_valid), 64'd0);
        chk("abort_sum", 64'(bus4.sum), 64'h0);
        chk("abort_cout", 64'(bus4.cout), 64'd0);
        chk("abort_busy", 64'(bus4.busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            seen = seen | bus4.out_valid;
        end
        chk("abort_no_out_valid", 64'(seen), 64'd0);

        run4(32'd5, 32'd7, 1'b0, lat);
        chk("fresh_latency", 64'(lat), 64'd4);
        chk("fresh_sum", 64'(bus4.sum), 64'd12);
        chk("fresh_cout", 64'(bus4.cout), 64'd0);
        release4();

`ifdef MWA_OVERFLOW_EN
        run4(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat);
        chk("ovf_pos_sum", 64'(bus4.sum), 64'h8000_0000);
        chk("ovf_pos_ovf", 64'(bus4.ovf), 64'd1);
        chk("ovf_pos_cout", 64'(bus4.cout), 64'd0);
        release4();
        run4(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat);
        chk("ovf_neg_ovf", 64'(bus4.ovf), 64'd0);
        chk("ovf_neg_cout", 64'(bus4.cout), 64'd1);
        release4();
`endif

        // Single-chunk build: one RUN cycle.
        @(posedge clk); #1;
        bus1.a = 8'hF0;
        bus1.b = 8'h20;
        bus1.cin = 1'b0;
        bus1.in_valid = 1'b1;
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        chk("n1_busy", 64'(bus1.busy), 64'd1);
        chk("n1_early_valid", 64'(bus1.out_valid), 64'd0);
        @(posedge clk); #1;
        chk("n1_out_valid", 64'(bus1.out_valid), 64'd1);
        chk("n1_sum", 64'(bus1.sum), 64'h10);
        chk("n1_cout", 64'(bus1.cout), 64'd1);
`ifdef MWA_OVERFLOW_EN
        chk("n1_ovf", 64'(bus1.ovf), 64'd0);
`endif
        bus1.out_ready = 1'b1;
        @(posedge clk); #1;
        bus1.out_ready = 1'b0;
        chk("n1_back_idle", 64'(bus1.in_ready), 64'd1);

        @(posedge clk); #1;
        bus1.a = 8'h7F;
        bus1.b = 8'h80;
        bus1.cin = 1'b1;
        bus1.in_valid = 1'b1;
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("n1_cin_sum", 64'(bus1.sum), 64'h00);
        chk("n1_cin_cout", 64'(bus1.cout), 64'd1);
        bus1.out_ready = 1'b1;
        @(posedge clk); #1;
        bus1.out_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
